// File: rtl/x_vector_fetch_if.sv
// Index, memory request/response, output and start channels of x_vector_fetch.
// master: the fetch unit; slave: index producer, memory and consumer side.
interface x_vector_fetch_if #(
  parameter int INDEX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_COUNT   = 4,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT)
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  start_addr;
  logic                   index_push;
  logic [INDEX_WIDTH-1:0] row;
  logic [INDEX_WIDTH-1:0] col;
  logic                   index_stall;
  logic                   req;
  logic                   req_stall;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   push;
  logic [TAG_WIDTH-1:0]   push_tag;
  logic [DATA_WIDTH-1:0]  data;
  logic                   out_push;
  logic                   out_stall;
  logic [INDEX_WIDTH-1:0] out_row;
  logic [INDEX_WIDTH-1:0] out_col;
  logic [DATA_WIDTH-1:0]  out_value;

  modport master (
    input  start, start_addr, index_push, row, col, req_stall, push, push_tag, data, out_stall,
    output index_stall, req, req_tag, req_addr, out_push, out_row, out_col, out_value
  );

  modport slave (
    output start, start_addr, index_push, row, col, req_stall, push, push_tag, data, out_stall,
    input  index_stall, req, req_tag, req_addr, out_push, out_row, out_col, out_value
  );
endinterface

// File: rtl/x_vector_fetch.sv
// Fetches x[col] per accepted (row,col) via a tagged memory port; a TAG_COUNT reorder ring restores order.
// Latency: accept -> req next cycle; response -> out_push next cycle when it is the head entry.
// Backpressure: index_stall when ring full or req stalled; out_* hold under out_stall. X_FETCH_STATS_EN adds counters.
module x_vector_fetch #(
  parameter int INDEX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_COUNT   = 4,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT)
) (
  input logic              clk,
  input logic              rst,
  x_vector_fetch_if.master bus
`ifdef X_FETCH_STATS_EN
  ,
  output logic [31:0]      stat_reqs,
  output logic [31:0]      stat_stall_cycles
`endif
);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = TAG_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]  base;
  logic [TAG_COUNT-1:0]   ent_vld;
  logic [TAG_COUNT-1:0]   ent_rdy;
  logic [INDEX_WIDTH-1:0] ent_row [TAG_COUNT];
  logic [INDEX_WIDTH-1:0] ent_col [TAG_COUNT];
  logic [DATA_WIDTH-1:0]  ent_dat [TAG_COUNT];
  logic [TAG_WIDTH-1:0]   alloc_ptr;
  logic [TAG_WIDTH-1:0]   head_ptr;
  logic [CNT_W-1:0]       count;

  logic                   resp_ok;
  logic                   head_rdy;
  logic [DATA_WIDTH-1:0]  head_dat;
  logic                   load;
  logic                   full;
  logic                   accept;
  logic                   req_done;
  logic                   start_ok;
  logic [ADDR_WIDTH-1:0]  col_addr;

  assign resp_ok  = bus.push && ent_vld[bus.push_tag] && !ent_rdy[bus.push_tag];
  // A response for the head entry bypasses the ring so it reaches the output one cycle later.
  assign head_rdy = ent_rdy[head_ptr] || (resp_ok && (bus.push_tag == head_ptr));
  assign head_dat = ent_rdy[head_ptr] ? ent_dat[head_ptr] : bus.data;
  assign load     = head_rdy && (!bus.out_push || !bus.out_stall);
  assign full     = (count == CNT_W'(TAG_COUNT)) && !load;
  assign bus.index_stall = full || (bus.req && bus.req_stall);
  assign accept   = bus.index_push && !bus.index_stall;
  assign req_done = bus.req && !bus.req_stall;
  assign start_ok = bus.start && (count == '0);
  assign col_addr = base + (ADDR_WIDTH'(bus.col) << SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base          <= '0;
      ent_vld       <= '0;
      ent_rdy       <= '0;
      alloc_ptr     <= '0;
      head_ptr      <= '0;
      count         <= '0;
      bus.req       <= 1'b0;
      bus.req_tag   <= '0;
      bus.req_addr  <= '0;
      bus.out_push  <= 1'b0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.out_value <= '0;
    end else begin
      if (start_ok) begin
        base <= bus.start_addr;
      end
      if (resp_ok) begin
        ent_rdy[bus.push_tag] <= 1'b1;
      end
      // Free after the response write so a bypassed head never stays marked ready.
      if (load) begin
        ent_vld[head_ptr] <= 1'b0;
        ent_rdy[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + TAG_WIDTH'(1);
        bus.out_push      <= 1'b1;
        bus.out_row       <= ent_row[head_ptr];
        bus.out_col       <= ent_col[head_ptr];
        bus.out_value     <= head_dat;
      end else if (!bus.out_stall) begin
        bus.out_push <= 1'b0;
      end
      // Allocation last: when full, the freed head slot is the one being reallocated.
      if (accept) begin
        ent_vld[alloc_ptr] <= 1'b1;
        ent_rdy[alloc_ptr] <= 1'b0;
        alloc_ptr          <= alloc_ptr + TAG_WIDTH'(1);
        bus.req            <= 1'b1;
        bus.req_tag        <= alloc_ptr;
        bus.req_addr       <= col_addr;
      end else if (req_done) begin
        bus.req <= 1'b0;
      end
      count <= count + CNT_W'(accept) - CNT_W'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_ok) begin
      ent_dat[bus.push_tag] <= bus.data;
    end
    if (accept) begin
      ent_row[alloc_ptr] <= bus.row;
      ent_col[alloc_ptr] <= bus.col;
    end
  end

`ifdef X_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reqs         <= '0;
      stat_stall_cycles <= '0;
    end else if (start_ok) begin
      stat_reqs         <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (req_done && (stat_reqs != '1)) begin
        stat_reqs <= stat_reqs + 32'd1;
      end
      if (bus.index_push && bus.index_stall && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif
endmodule
